motion_box_detect: RTL and testbench

MOTION_BOX_DETECT -- requirements
Module: motion_box_detect

---
 rtl/motion_box_detect_pkg.sv | 35 +++
 rtl/motion_box_detect_if.sv | 23 ++
 rtl/motion_box_accum.sv | 71 +++++++
 rtl/motion_box_detect.sv | 104 ++++++++++
 tb/tb_motion_box_detect.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/motion_box_detect_pkg.sv
// Shared types and constants for the motion bounding-box detector.
package motion_box_detect_pkg;

  localparam int IMG_HDISP_DEF = 640;
  localparam int IMG_VDISP_DEF = 480;

  localparam int COORD_W = 11;
  localparam int CNT_W   = 20;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   count_t;

  localparam coord_t MIN_INIT = 11'h7FF;
  localparam count_t CNT_MAX  = 20'hFFFFF;

  typedef struct packed {
    coord_t x_min;
    coord_t x_max;
    coord_t y_min;
    coord_t y_max;
  } box_t;

  // Min fields start high and max fields low so the first hit overwrites both.
  localparam box_t BOX_INIT = '{x_min: MIN_INIT, x_max: '0, y_min: MIN_INIT, y_max: '0};

  // True when (x, y) lies on the perimeter of box b.
  function automatic logic on_outline(input coord_t x, input coord_t y, input box_t b);
    logic on_col;
    logic on_row;
    on_col = ((x == b.x_min) || (x == b.x_max)) && (y >= b.y_min) && (y <= b.y_max);
    on_row = ((y == b.y_min) || (y == b.y_max)) && (x >= b.x_min) && (x <= b.x_max);
    return on_col | on_row;
  endfunction

endpackage

// File: rtl/motion_box_detect_if.sv
// Binary video stream: frame sync, line valid, pixel qualifier and one motion bit.
interface motion_box_detect_if;

  logic frame_vsync;
  logic frame_href;
  logic frame_clken;
  logic img_bit;

  modport master (
    output frame_vsync,
    output frame_href,
    output frame_clken,
    output img_bit
  );

  modport slave (
    input frame_vsync,
    input frame_href,
    input frame_clken,
    input img_bit
  );

endinterface

// File: rtl/motion_box_accum.sv
// Pixel coordinate counters plus running min/max/count of motion pixels for the
// frame in progress. The frame-close pulse comes from the top level.
module motion_box_accum
  import motion_box_detect_pkg::*;
#(
  parameter int IMG_HDISP = IMG_HDISP_DEF,
  parameter int IMG_VDISP = IMG_VDISP_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   href,
  input  logic   clken,
  input  logic   pix,
  input  logic   frame_close,
  output coord_t x,
  output coord_t y,
  output box_t   acc_box,
  output count_t acc_cnt
);

  localparam coord_t X_LAST = coord_t'(IMG_HDISP - 1);
  localparam coord_t Y_LAST = coord_t'(IMG_VDISP - 1);

  logic href_d;
  logic accept;
  logic line_end;
  logic hit;

  assign accept   = href & clken;
  assign line_end = href_d & ~href;
  // A hit landing on the frame-close cycle belongs to neither frame and is dropped.
  assign hit      = accept & pix & ~frame_close;

  // Delayed line-valid for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) href_d <= 1'b0;
    else        href_d <= href;
  end

  // Column counter: restarts every line, advances per accepted pixel, holds at the last column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        x <= '0;
    else if (!href)                    x <= '0;
    else if (accept && (x != X_LAST))  x <= x + 1'b1;
  end

  // Row counter: restarts at frame close, advances at each line end, holds at the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          y <= '0;
    else if (frame_close)                y <= '0;
    else if (line_end && (y != Y_LAST))  y <= y + 1'b1;
  end

  // Bounding-box and pixel-count accumulation for the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_box <= BOX_INIT;
      acc_cnt <= '0;
    end else if (frame_close) begin
      acc_box <= BOX_INIT;
      acc_cnt <= '0;
    end else if (hit) begin
      if (x < acc_box.x_min) acc_box.x_min <= x;
      if (x > acc_box.x_max) acc_box.x_max <= x;
      if (y < acc_box.y_min) acc_box.y_min <= y;
      if (y > acc_box.y_max) acc_box.y_max <= y;
      if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/motion_box_detect.sv
// Motion bounding-box detector: latches the box of each frame's motion pixels at
// frame close and overlays the previous frame's box outline onto the stream.
module motion_box_detect
  import motion_box_detect_pkg::*;
#(
  parameter int IMG_HDISP  = IMG_HDISP_DEF,
  parameter int IMG_VDISP  = IMG_VDISP_DEF,
  parameter int MIN_PIXELS = 32
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  motion_box_detect_if.slave       per_bus,
  motion_box_detect_if.master      post_bus,
  output logic [COORD_W-1:0]       box_x_min,
  output logic [COORD_W-1:0]       box_x_max,
  output logic [COORD_W-1:0]       box_y_min,
  output logic [COORD_W-1:0]       box_y_max,
  output logic [CNT_W-1:0]         box_pixel_cnt,
  output logic                     box_valid,
  output logic                     box_update
);

  localparam count_t MIN_CNT = count_t'(MIN_PIXELS);

  logic   vsync_d;
  logic   frame_close;
  logic   accept;
  logic   outline;
  coord_t x;
  coord_t y;
  box_t   acc_box;
  count_t acc_cnt;
  box_t   box_q;

  assign accept      = per_bus.frame_href & per_bus.frame_clken;
  assign frame_close = vsync_d & ~per_bus.frame_vsync;
  // Overlay always uses the latched box, never the in-progress accumulators.
  assign outline     = box_valid & on_outline(x, y, box_q);

  assign box_x_min = box_q.x_min;
  assign box_x_max = box_q.x_max;
  assign box_y_min = box_q.y_min;
  assign box_y_max = box_q.y_max;

  motion_box_accum #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP)
  ) u_accum (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .href        (per_bus.frame_href),
    .clken       (per_bus.frame_clken),
    .pix         (per_bus.img_bit),
    .frame_close (frame_close),
    .x           (x),
    .y           (y),
    .acc_box     (acc_box),
    .acc_cnt     (acc_cnt)
  );

  // Delayed frame sync for falling-edge (frame close) detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) vsync_d <= 1'b0;
    else            vsync_d <= per_bus.frame_vsync;
  end

  // Latch the finished frame's box at frame close; undersized frames report an empty box.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      box_q         <= '0;
      box_pixel_cnt <= '0;
      box_valid     <= 1'b0;
      box_update    <= 1'b0;
    end else begin
      box_update <= frame_close;
      if (frame_close) begin
        box_pixel_cnt <= acc_cnt;
        if (acc_cnt >= MIN_CNT) begin
          box_q     <= acc_box;
          box_valid <= 1'b1;
        end else begin
          box_q     <= '0;
          box_valid <= 1'b0;
        end
      end
    end
  end

  // One-cycle delayed sync and overlaid pixel, both taken from the same input cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      post_bus.frame_vsync <= 1'b0;
      post_bus.frame_href  <= 1'b0;
      post_bus.frame_clken <= 1'b0;
      post_bus.img_bit     <= 1'b0;
    end else begin
      post_bus.frame_vsync <= per_bus.frame_vsync;
      post_bus.frame_href  <= per_bus.frame_href;
      post_bus.frame_clken <= per_bus.frame_clken;
      post_bus.img_bit     <= accept & (per_bus.img_bit | outline);
    end
  end

endmodule

// File: tb/tb_motion_box_detect.sv
// Directed bench for motion_box_detect: three instances share one input stream
// and differ only in MIN_PIXELS (2 = main, 3 and 1 = threshold variants).
module tb_motion_box_detect;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;

  // 100 MHz bench clock.
  always #5 sys_clk = ~sys_clk;

  motion_box_detect_if per_bus ();
  motion_box_detect_if post_2 ();
  motion_box_detect_if post_3 ();
  motion_box_detect_if post_1 ();

  logic [10:0] xmin_2, xmax_2, ymin_2, ymax_2;
  logic [19:0] cnt_2;
  logic        valid_2, update_2;
  logic [10:0] xmin_3, xmax_3, ymin_3, ymax_3;
  logic [19:0] cnt_3;
  logic        valid_3, update_3;
  logic [10:0] xmin_1, xmax_1, ymin_1, ymax_1;
  logic [19:0] cnt_1;
  logic        valid_1, update_1;

  motion_box_detect #(.IMG_HDISP(640), .IMG_VDISP(480), .MIN_PIXELS(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .per_bus(per_bus), .post_bus(post_2),
    .box_x_min(xmin_2), .box_x_max(xmax_2), .box_y_min(ymin_2), .box_y_max(ymax_2),
    .box_pixel_cnt(cnt_2), .box_valid(valid_2), .box_update(update_2)
  );

  motion_box_detect #(.IMG_HDISP(640), .IMG_VDISP(480), .MIN_PIXELS(3)) dut_m3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .per_bus(per_bus), .post_bus(post_3),
    .box_x_min(xmin_3), .box_x_max(xmax_3), .box_y_min(ymin_3), .box_y_max(ymax_3),
    .box_pixel_cnt(cnt_3), .box_valid(valid_3), .box_update(update_3)
  );

  motion_box_detect #(.IMG_HDISP(640), .IMG_VDISP(480), .MIN_PIXELS(1)) dut_m1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .per_bus(per_bus), .post_bus(post_1),
    .box_x_min(xmin_1), .box_x_max(xmax_1), .box_y_min(ymin_1), .box_y_max(ymax_1),
    .box_pixel_cnt(cnt_1), .box_valid(valid_1), .box_update(update_1)
  );

  int   checks   = 0;
  int   failures = 0;
  int   mode     = 0;
  logic prevVs   = 1'b0;
  logic expValid = 1'b0;
  int   bx0 = 0, bx1 = 0, by0 = 0, by1 = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected box perimeter test for the box the main instance currently holds.
  function automatic logic onRect(input int x, input int y);
    return (((x == bx0) || (x == bx1)) && (y >= by0) && (y <= by1)) ||
           (((y == by0) || (y == by1)) && (x >= bx0) && (x <= bx1));
  endfunction

  function automatic logic motionAt(input int m, input int line, input int i);
    case (m)
      0:       return ((line == 50) && (i == 100)) || ((line == 200) && (i == 300));
      2:       return (line == 0) || (line == 481);
      3:       return (line == 479) && (i == 639);
      4:       return (line == 100) && (i == 120);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int lineLen(input int m, input int line);
    case (m)
      0:       return ((line == 50) || (line == 200)) ? 320 : 0;
      1:       return ((line == 49) || (line == 50) || (line == 51) || (line == 125) ||
                       (line == 200) || (line == 201)) ? 320 : 0;
      2:       return (line == 0) ? 700 : ((line == 481) ? 640 : 0);
      3:       return (line == 479) ? 640 : 0;
      4:       return (line == 100) ? 200 : 0;
      default: return 0;
    endcase
  endfunction

  // Drive one input cycle, then check the one-cycle-delayed outputs of the main instance.
  task automatic applyStimulus(input logic vs, input logic hr, input logic ck, input logic px, input logic expPix);
    per_bus.frame_vsync = vs;
    per_bus.frame_href  = hr;
    per_bus.frame_clken = ck;
    per_bus.img_bit     = px;
    @(posedge sys_clk);
    #1;
    checkOutput("post_vsync", 32'(post_2.frame_vsync), 32'(vs));
    checkOutput("post_href", 32'(post_2.frame_href), 32'(hr));
    checkOutput("post_clken", 32'(post_2.frame_clken), 32'(ck));
    checkOutput("post_img_bit", 32'(post_2.img_bit), 32'(expPix));
    checkOutput("box_update", 32'(update_2), 32'(prevVs & ~vs));
    prevVs = vs;
  endtask

  task automatic pulseReset();
    sys_rst_n = 1'b0;
    #1;
    checkOutput("rst_x_min", 32'(xmin_2), 0);
    checkOutput("rst_x_max", 32'(xmax_2), 0);
    checkOutput("rst_y_min", 32'(ymin_2), 0);
    checkOutput("rst_y_max", 32'(ymax_2), 0);
    checkOutput("rst_cnt", 32'(cnt_2), 0);
    checkOutput("rst_valid", 32'(valid_2), 0);
    checkOutput("rst_update", 32'(update_2), 0);
    checkOutput("rst_post_vsync", 32'(post_2.frame_vsync), 0);
    checkOutput("rst_post_href", 32'(post_2.frame_href), 0);
    checkOutput("rst_post_img_bit", 32'(post_2.img_bit), 0);
    checkOutput("rst_m3_cnt", 32'(cnt_3), 0);
    prevVs   = 1'b0;
    expValid = 1'b0;
    bx0 = 0; bx1 = 0; by0 = 0; by1 = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic sendLine(input int line, input int len);
    int y;
    int x;
    logic px;
    y = (line > 479) ? 479 : line;
    if (len == 0) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (i == 10) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      px = motionAt(mode, line, i);
      x  = (i > 639) ? 639 : i;
      applyStimulus(1'b1, 1'b1, 1'b1, px, px | (expValid & onRect(x, y)));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendFrame(input int m, input int nLines);
    mode = m;
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int line = 0; line < nLines; line++) begin
      if ((m == 4) && (line == 240)) pulseReset();
      sendLine(line, lineLen(m, line));
    end
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Drop vsync, check the latched box of the main instance, and adopt it as the overlay model.
  task automatic closeFrame(input logic dropPix, input int cnt, input logic valid,
                            input int x0, input int x1, input int y0, input int y1);
    applyStimulus(1'b0, dropPix, dropPix, dropPix, dropPix);
    checkOutput("close_cnt", 32'(cnt_2), cnt);
    checkOutput("close_valid", 32'(valid_2), 32'(valid));
    checkOutput("close_x_min", 32'(xmin_2), x0);
    checkOutput("close_x_max", 32'(xmax_2), x1);
    checkOutput("close_y_min", 32'(ymin_2), y0);
    checkOutput("close_y_max", 32'(ymax_2), y1);
    expValid = valid;
    bx0 = x0; bx1 = x1; by0 = y0; by1 = y1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Main directed sequence.
  initial begin
    per_bus.frame_vsync = 1'b0;
    per_bus.frame_href  = 1'b0;
    per_bus.frame_clken = 1'b0;
    per_bus.img_bit     = 1'b0;
    #2;
    pulseReset();

    sendFrame(0, 480);
    closeFrame(1'b0, 2, 1'b1, 100, 300, 50, 200);
    checkOutput("m3_cnt", 32'(cnt_3), 2);
    checkOutput("m3_valid", 32'(valid_3), 0);
    checkOutput("m3_x_min", 32'(xmin_3), 0);
    checkOutput("m3_x_max", 32'(xmax_3), 0);
    checkOutput("m3_y_min", 32'(ymin_3), 0);
    checkOutput("m3_y_max", 32'(ymax_3), 0);
    checkOutput("m1_valid", 32'(valid_1), 1);

    sendFrame(1, 480);
    closeFrame(1'b0, 0, 1'b0, 0, 0, 0, 0);
    checkOutput("m3_cnt_empty", 32'(cnt_3), 0);

    sendFrame(2, 482);
    closeFrame(1'b0, 1340, 1'b1, 0, 639, 0, 479);
    checkOutput("m3_cnt_edges", 32'(cnt_3), 1340);
    checkOutput("m3_valid_edges", 32'(valid_3), 1);

    sendFrame(3, 480);
    closeFrame(1'b0, 1, 1'b0, 0, 0, 0, 0);
    checkOutput("m1_x_min", 32'(xmin_1), 639);
    checkOutput("m1_x_max", 32'(xmax_1), 639);
    checkOutput("m1_y_min", 32'(ymin_1), 479);
    checkOutput("m1_y_max", 32'(ymax_1), 479);
    checkOutput("m1_cnt", 32'(cnt_1), 1);
    checkOutput("m1_valid_single", 32'(valid_1), 1);

    sendFrame(4, 480);
    closeFrame(1'b0, 0, 1'b0, 0, 0, 0, 0);

    sendFrame(0, 480);
    closeFrame(1'b1, 2, 1'b1, 100, 300, 50, 200);

    sendFrame(5, 0);
    closeFrame(1'b0, 0, 1'b0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #3000000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
